reset_conditioner: RTL and testbench

- Consumer end of the bench clock/reset generator.
- Takes a raw, possibly asynchronous reset request, synchronises it into the `clk` domain and stretches it to a guaranteed minimum length.
- Drives a clean `rst_out` to downstream logic such as the LFSR cores.
- Reports a free-running cycle count since the last release, a count of reset events, and detection of too-short request pulses.

---
 rtl/reset_conditioner.sv | 115 +++++++++++
 tb/tb_reset_conditioner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/reset_conditioner.sv
// rtl/reset_conditioner.sv - synchronise, stretch and monitor a raw reset request
// RESET_COND_GLITCH_FILTER_EN: RUN only resets on synchronised requests of MIN_PULSE+ cycles.
module reset_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HOLD    = 8,
  parameter int MIN_PULSE   = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rst_req_in,
  output logic             rst_out,
  output logic             ready,
  output logic [CNT_W-1:0] cycle_count,
  output logic [7:0]       reset_events,
  output logic             short_req
);

  localparam int HOLD_W  = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam int PULSE_W = $clog2(MIN_PULSE + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
  localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(MIN_PULSE);

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  state_t                 state_q;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [PULSE_W-1:0]     pulse_cnt_q;
  logic [PULSE_W-1:0]     pulse_cnt_d;
  logic [CNT_W-1:0]       cycle_count_q;
  logic [7:0]             reset_events_q;
  logic                   rst_out_q;
  logic                   ready_q;
  logic                   short_req_q;
  logic                   short_req_d;
  logic                   req_s;
  logic                   trigger;

  assign req_s = sync_q[SYNC_STAGES-1];

`ifdef RESET_COND_GLITCH_FILTER_EN
  assign trigger = req_s && (pulse_cnt_q >= PULSE_W'(MIN_PULSE - 1));
`else
  assign trigger = req_s;
`endif

  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    if (!req_s) begin
      pulse_cnt_d = '0;
    end else if (pulse_cnt_q != PULSE_MAX) begin
      pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
    end
  end

  // A nonzero pulse count with req_s now low marks the falling edge of a counted pulse.
  assign short_req_d = !req_s && (pulse_cnt_q != '0) && (pulse_cnt_q < PULSE_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q         <= '1;
      state_q        <= ST_HOLD;
      hold_cnt_q     <= '0;
      pulse_cnt_q    <= '0;
      cycle_count_q  <= '0;
      reset_events_q <= '0;
      rst_out_q      <= 1'b1;
      ready_q        <= 1'b0;
      short_req_q    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rst_req_in};
      pulse_cnt_q <= pulse_cnt_d;
      short_req_q <= short_req_d;
      case (state_q)
        ST_HOLD: begin
          cycle_count_q <= '0;
          if (req_s) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q       <= ST_RUN;
            hold_cnt_q    <= '0;
            rst_out_q     <= 1'b0;
            ready_q       <= 1'b1;
            cycle_count_q <= CNT_W'(1);
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (trigger) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            rst_out_q     <= 1'b1;
            ready_q       <= 1'b0;
            cycle_count_q <= '0;
            if (reset_events_q != 8'hFF) begin
              reset_events_q <= reset_events_q + 8'd1;
            end
          end else if (cycle_count_q != '1) begin
            cycle_count_q <= cycle_count_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_HOLD;
      endcase
    end
  end

  assign rst_out      = rst_out_q;
  assign ready        = ready_q;
  assign cycle_count  = cycle_count_q;
  assign reset_events = reset_events_q;
  assign short_req    = short_req_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// tb/tb_reset_conditioner.sv - directed self-checking bench for reset_conditioner
module tb_reset_conditioner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst_req_in = 1'b0;
  logic        rst_out, ready, short_req;
  logic [31:0] cycle_count;
  logic [7:0]  reset_events;
  logic        sat_rst_out, sat_ready, sat_short_req;
  logic [3:0]  sat_cycle_count;
  logic [7:0]  sat_reset_events;

  int n_cmp = 0;
  int n_bad = 0;
  int short_total = 0;
  int exp_ev = 0;
  int n;
  int hi;
  int s0;

  always #10 clk = ~clk;

  always @(negedge clk) if (short_req === 1'b1) short_total++;

  reset_conditioner u_dut (
    .clk(clk), .reset(reset), .rst_req_in(rst_req_in),
    .rst_out(rst_out), .ready(ready), .cycle_count(cycle_count),
    .reset_events(reset_events), .short_req(short_req)
  );

  reset_conditioner #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .rst_req_in(rst_req_in),
    .rst_out(sat_rst_out), .ready(sat_ready), .cycle_count(sat_cycle_count),
    .reset_events(sat_reset_events), .short_req(sat_short_req)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rst(input logic level, input int limit, output int cnt);
    cnt = 0;
    while (rst_out !== level && cnt < limit) begin
      tick();
      cnt++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rst_out"}, rst_out, 1);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
    check({tag, "_reset_events"}, reset_events, 0);
    check({tag, "_short_req"}, short_req, 0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_values("por");
    reset = 1'b0;
    wait_rst(1'b0, 50, n);
    check("por_hold_len", n, 10);
    check("por_ready", ready, 1);
    check("por_first_count", cycle_count, 1);
    check("por_events", reset_events, 0);

    // Long request: 10 cycles (200 ns) of raw request
    rst_req_in = 1'b1;
    wait_rst(1'b1, 20, n);
`ifdef RESET_COND_GLITCH_FILTER_EN
    check("long_assert_latency", n, 4);
`else
    check("long_assert_latency", n, 3);
`endif
    exp_ev++;
    check("long_events", reset_events, exp_ev);
    check("long_count_clear", cycle_count, 0);
    check("long_ready_low", ready, 0);
    repeat (10 - n) tick();
    rst_req_in = 1'b0;
    wait_rst(1'b0, 40, n);
    check("long_release_len", n, 10);
    check("long_run_count", cycle_count, 1);
    check("long_no_short", short_total, 0);
    repeat (5) tick();
    check("run_count", cycle_count, 6);

    // Short request: one raw cycle
    s0 = short_total;
    rst_req_in = 1'b1;
    tick();
    rst_req_in = 1'b0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rst_out === 1'b1) hi++;
    end
    check("short_pulses", short_total - s0, 1);
`ifdef RESET_COND_GLITCH_FILTER_EN
    check("short_rst_high", hi, 0);
    check("short_count", cycle_count, 27);
`else
    exp_ev++;
    check("short_rst_high", hi, 8);
    check("short_count", cycle_count, 11);
`endif
    check("short_events", reset_events, exp_ev);

    // Re-assert 4 cycles into the hold
    s0 = short_total;
    rst_req_in = 1'b1;
    wait_rst(1'b1, 20, n);
    check("reassert_rose", rst_out, 1);
    exp_ev++;
    rst_req_in = 1'b0;
    repeat (6) tick();
    check("reassert_still_hold", rst_out, 1);
    rst_req_in = 1'b1;
    tick();
    rst_req_in = 1'b0;
    n = 7;
    while (rst_out !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    check("reassert_hold_len", n, 17);
    check("reassert_events", reset_events, exp_ev);
    check("reassert_short", short_total - s0, 1);

    // Saturation of the 4-bit counter, then a request clears it
    repeat (20) tick();
    check("sat_count_wide", cycle_count, 21);
    check("sat_count_narrow", sat_cycle_count, 15);
    rst_req_in = 1'b1;
    wait_rst(1'b1, 20, n);
    exp_ev++;
    check("sat_clear_narrow", sat_cycle_count, 0);
    check("sat_clear_wide", cycle_count, 0);
    check("sat_events", reset_events, exp_ev);
    rst_req_in = 1'b0;
    wait_rst(1'b0, 40, n);
    check("sat_back_ready", ready, 1);

    // Mid-operation reset
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_reset_values("mid");
    check("mid_sat_count", sat_cycle_count, 0);
    reset = 1'b0;
    wait_rst(1'b0, 50, n);
    check("mid_hold_len", n, 10);
    check("mid_first_count", cycle_count, 1);
    check("mid_events", reset_events, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
